bist_controller: RTL and testbench
==================================

// Module: bist_controller
// PURPOSE
//  Sequences one logic-BIST session for the c432 CUT. Drives the BIST select of the 36-input
//  functional/BIST input mux, steps the TPG (LFSR) and ORA (MISR), counts applied patterns, and
//  compares the final MISR signature against a golden value. Sits between the top-level test
//  interface (start/abort/status) and the TPG, mux, CUT and ORA datapath.
// PARAMETERS
//  N_PATTERNS  1000         patterns applied per session, legal range 1..2**CNT_W-1
//  CNT_W       16           pattern-counter width
//  FLUSH_CYC   1            cycles ORA keeps capturing after the last pattern; legal range 1..15
//  SIG_W       7            MISR width, one bit per CUT output
//  GOLDEN_SIG  7'h00        expected fault-free signature
// PORTS
//  clk         in   1       sole clock, rising edge
//  rst_n       in   1       synchronous, active-low reset
//  bist_start  in   1       level request; sampled in IDLE and DONE only
//  bist_abort  in   1       abort current session; has priority over everything except rst_n
//  sig_in      in   SIG_W   current MISR contents
//  bist_mode   out  1       select to input mux: 1 = TPG patterns, 0 = functional inputs
//  tpg_load    out  1       load LFSR seed (one-cycle pulse)
//  tpg_en      out  1       advance LFSR
//  ora_clr     out  1       clear MISR to 0 (one-cycle pulse)
//  ora_en      out  1       MISR captures CUT outputs
//  pat_count   out  CNT_W   patterns applied so far in this session
//  bist_busy   out  1       session in progress (INIT..COMPARE)
//  bist_done   out  1       session complete, result valid
//  bist_pass   out  1       1 = sig matched GOLDEN_SIG; qualified by bist_done
// BEHAVIOUR
//  - All outputs registered (Moore). On rst_n=0 at a clock edge: state=IDLE, every output 0.
//  - FSM: IDLE -> INIT -> RUN -> FLUSH -> COMPARE -> DONE.
//  - IDLE: all outputs 0. bist_start=1 -> INIT.
//  - INIT (1 cycle): bist_mode=1, tpg_load=1, ora_clr=1, busy=1, pat_count<=0 -> RUN.
//  - RUN: bist_mode=1, tpg_en=1, ora_en=1, busy=1; pat_count increments each cycle. Exactly
//    N_PATTERNS RUN cycles; on the cycle pat_count reaches N_PATTERNS -> FLUSH. pat_count never
//    wraps: it saturates at N_PATTERNS.
//  - FLUSH: FLUSH_CYC cycles with ora_en=1, tpg_en=0, bist_mode=1. Uses its own
//    4-bit down-counter -> COMPARE.
//  - COMPARE (1 cycle): ora_en=0. bist_pass<=(sig_in==GOLDEN_SIG). bist_mode stays 1 to keep
//    CUT inputs stable -> DONE.
//  - DONE: bist_done=1, bist_pass held, busy=0, bist_mode=0, pat_count held. bist_start=0 -> IDLE
//    (done/pass clear). A held start does not retrigger; software must drop start to rerun.
//  - bist_abort=1 in any state: next state IDLE, all outputs 0 the next cycle, no result reported.
//    An abort and start asserted in the same IDLE cycle -> stays IDLE.
//  - tpg_load and ora_clr are never asserted with tpg_en or ora_en in the same cycle.
//  - Latency: start sampled at edge k -> INIT outputs at k+1, first RUN at k+2, bist_done at
//    k+2+N_PATTERNS+FLUSH_CYC+1.
// STRUCTURE
//  - bist_pkg: state enum (IDLE, INIT, RUN, FLUSH, COMPARE, DONE), state-width localparam.
//  - One sub-module: bist_pat_counter (saturating up-counter, clear/enable, terminal-count flag).
//  - Output decode in one registered block keyed on next state.
// TESTING (N_PATTERNS=8, FLUSH_CYC=1, GOLDEN_SIG=7'h2A unless stated)
//  1 reset: rst_n=0 for 2 cycles mid-RUN -> all outputs 0, state IDLE next cycle.
//  2 pass: start=1, sig_in=7'h2A at COMPARE -> tpg_load/ora_clr 1 cycle, tpg_en high exactly 8
//    cycles, ora_en 9 cycles, done=1 & pass=1 at start+12, pat_count=8.
//  3 fail: same with sig_in=7'h2B -> done=1, pass=0; drop start -> IDLE, done=0 next cycle.
//  4 abort: abort=1 at RUN cycle 4 -> next cycle all outputs 0, done never asserts, pat_count=0.
//  5 hold start: start held high after DONE -> stays DONE; drop then raise -> new session,
//    pat_count restarts at 0.
//  6 edge: N_PATTERNS=1, FLUSH_CYC=3 -> tpg_en 1 cycle, ora_en 4 cycles, done at start+7.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared types for the logic-BIST session controller.
package bist_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 3'd0,
    INIT    = 3'd1,
    RUN     = 3'd2,
    FLUSH   = 3'd3,
    COMPARE = 3'd4,
    DONE    = 3'd5
  } bist_state_e;

endpackage

// File: rtl/bist_pat_counter.sv
// Saturating pattern counter; last flags the increment that reaches MAX_CNT.
module bist_pat_counter #(
  parameter int CNT_W   = 16,
  parameter int MAX_CNT = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  localparam logic [CNT_W-1:0] MAX_V  = CNT_W'(MAX_CNT);
  localparam logic [CNT_W-1:0] LAST_V = CNT_W'(MAX_CNT - 1);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      count <= '0;
    end else if (en && (count != MAX_V)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign last = en && (count == LAST_V);

endmodule

// File: rtl/bist_controller.sv
// Logic-BIST session sequencer: drives TPG/ORA controls, counts patterns and
// checks the final MISR signature against the golden value.
module bist_controller
  import bist_pkg::*;
#(
  parameter int               N_PATTERNS = 1000,
  parameter int               CNT_W      = 16,
  parameter int               FLUSH_CYC  = 1,
  parameter int               SIG_W      = 7,
  parameter logic [SIG_W-1:0] GOLDEN_SIG = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bist_start,
  input  logic             bist_abort,
  input  logic [SIG_W-1:0] sig_in,
  output logic             bist_mode,
  output logic             tpg_load,
  output logic             tpg_en,
  output logic             ora_clr,
  output logic             ora_en,
  output logic [CNT_W-1:0] pat_count,
  output logic             bist_busy,
  output logic             bist_done,
  output logic             bist_pass
);

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYC - 1);

  bist_state_e state_q, state_d;
  logic [3:0]  flush_q;
  logic        cnt_clr, cnt_en, cnt_last;

  always_comb begin
    state_d = state_q;
    if (bist_abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (bist_start) state_d = INIT;
        INIT:    state_d = RUN;
        RUN:     if (cnt_last) state_d = FLUSH;
        FLUSH:   if (flush_q == 4'd0) state_d = COMPARE;
        COMPARE: state_d = DONE;
        DONE:    if (!bist_start) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // The flush counter is preloaded throughout RUN so it is ready on FLUSH entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flush_q <= 4'd0;
    end else if (state_q == RUN) begin
      flush_q <= FLUSH_LOAD;
    end else if ((state_q == FLUSH) && (flush_q != 4'd0)) begin
      flush_q <= flush_q - 4'd1;
    end
  end

  // Count is zero while idle or initialising; abort therefore also clears it.
  assign cnt_clr = (state_d == IDLE) || (state_d == INIT);
  assign cnt_en  = (state_q == RUN);

  bist_pat_counter #(
    .CNT_W   (CNT_W),
    .MAX_CNT (N_PATTERNS)
  ) u_pat_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (pat_count),
    .last  (cnt_last)
  );

  // Moore outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bist_mode <= 1'b0;
      tpg_load  <= 1'b0;
      tpg_en    <= 1'b0;
      ora_clr   <= 1'b0;
      ora_en    <= 1'b0;
      bist_busy <= 1'b0;
      bist_done <= 1'b0;
      bist_pass <= 1'b0;
    end else begin
      bist_mode <= state_d inside {INIT, RUN, FLUSH, COMPARE};
      tpg_load  <= (state_d == INIT);
      ora_clr   <= (state_d == INIT);
      tpg_en    <= (state_d == RUN);
      ora_en    <= (state_d == RUN) || (state_d == FLUSH);
      bist_busy <= state_d inside {INIT, RUN, FLUSH, COMPARE};
      bist_done <= (state_d == DONE);
      if (state_d != DONE) begin
        bist_pass <= 1'b0;
      end else if (state_q == COMPARE) begin
        bist_pass <= (sig_in == GOLDEN_SIG);
      end
    end
  end

endmodule

// File: tb/tb_bist_controller.sv
// Bench for bist_controller: two instances (8 patterns/1 flush, 1 pattern/3 flush)
// checked cycle by cycle against a phase-table model of a BIST session.
module tb_bist_controller;

  localparam logic [6:0] GOLD = 7'h2A;

  logic        clk = 1'b0;
  logic        rst_n, abort, start0, start1;
  logic [6:0]  sig_in;
  logic        mode0, load0, tpgen0, clr0, oraen0, busy0, done0, pass0;
  logic        mode1, load1, tpgen1, clr1, oraen1, busy1, done1, pass1;
  logic [15:0] pc0, pc1;
  logic [7:0]  fl0, fl1;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] tr_fl [64];
  int         tr_pc [64];
  int         tr_len;

  always #5 clk = ~clk;

  bist_controller #(.N_PATTERNS(8), .CNT_W(16), .FLUSH_CYC(1), .SIG_W(7), .GOLDEN_SIG(GOLD)) u_main (
    .clk(clk), .rst_n(rst_n), .bist_start(start0), .bist_abort(abort), .sig_in(sig_in),
    .bist_mode(mode0), .tpg_load(load0), .tpg_en(tpgen0), .ora_clr(clr0), .ora_en(oraen0),
    .pat_count(pc0), .bist_busy(busy0), .bist_done(done0), .bist_pass(pass0));

  bist_controller #(.N_PATTERNS(1), .CNT_W(16), .FLUSH_CYC(3), .SIG_W(7), .GOLDEN_SIG(GOLD)) u_edge (
    .clk(clk), .rst_n(rst_n), .bist_start(start1), .bist_abort(abort), .sig_in(sig_in),
    .bist_mode(mode1), .tpg_load(load1), .tpg_en(tpgen1), .ora_clr(clr1), .ora_en(oraen1),
    .pat_count(pc1), .bist_busy(busy1), .bist_done(done1), .bist_pass(pass1));

  // Flag order: {mode, load, tpg_en, clr, ora_en, busy, done, pass}
  assign fl0 = {mode0, load0, tpgen0, clr0, oraen0, busy0, done0, pass0};
  assign fl1 = {mode1, load1, tpgen1, clr1, oraen1, busy1, done1, pass1};

  // Session model: m = cycles after the edge that samples start (m=0 is INIT).
  function automatic logic [7:0] model_fl(int m, int n, int f, logic ep, int ab, int hold);
    int dm = n + f + 2;
    if ((ab >= 0 && m > ab) || m > dm + hold) return 8'b0000_0000;
    if (m == 0)         return 8'b1101_0100;
    if (m <= n)         return 8'b1010_1100;
    if (m <= n + f)     return 8'b1000_1100;
    if (m == n + f + 1) return 8'b1000_0100;
    return {6'b0, 1'b1, ep};
  endfunction

  function automatic int model_pc(int m, int n, int f, int ab, int hold);
    int dm = n + f + 2;
    if ((ab >= 0 && m > ab) || m > dm + hold) return 0;
    if (m == 0) return 0;
    if (m <= n) return m - 1;
    return n;
  endfunction

  function automatic int n_of(int inst);
    return (inst == 0) ? 8 : 1;
  endfunction

  function automatic int f_of(int inst);
    return (inst == 0) ? 1 : 3;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input int inst, input logic v);
    if (inst == 0) start0 = v;
    else           start1 = v;
  endtask

  // Drives one session and records the outputs; sig_in is random except in COMPARE.
  task automatic run_session(input int inst, input logic [6:0] sig, input int ab, input int hold);
    int n  = n_of(inst);
    int f  = f_of(inst);
    int dm = n + f + 2;
    tr_len = (ab >= 0) ? ab + 5 : dm + hold + 2;
    sig_in = 7'($urandom);
    set_start(inst, 1'b1);
    for (int m = 0; m < tr_len; m++) begin
      tick();
      tr_fl[m] = (inst == 0) ? fl0 : fl1;
      tr_pc[m] = (inst == 0) ? int'(pc0) : int'(pc1);
      sig_in = (m == n + f + 1) ? sig : 7'($urandom);
      if (ab >= 0 && m == ab) begin
        abort = 1'b1;
        set_start(inst, 1'b0);
      end
      if (ab >= 0 && m == ab + 1) abort = 1'b0;
      if (ab < 0 && m == dm + hold) set_start(inst, 1'b0);
    end
    abort = 1'b0;
    set_start(inst, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    start0 = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    rst_n  = 1'b0;
    start0 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (k == 1) rst_n = 1'b1;
      vectors++;
      if (fl0 !== 8'h00) begin
        miscompares++;
        $display("FAIL reset_flags main cyc %0d got %b want %b", k, fl0, 8'h00);
      end
      vectors++;
      if (pc0 !== 16'd0) begin
        miscompares++;
        $display("FAIL reset_pat main cyc %0d got %0d want 0", k, pc0);
      end
      vectors++;
      if (fl1 !== 8'h00 || pc1 !== 16'd0) begin
        miscompares++;
        $display("FAIL reset_edge cyc %0d got %b/%0d want 0/0", k, fl1, pc1);
      end
    end
  endtask

  task automatic test_pass();
    int n_tpg = 0;
    int n_ora = 0;
    run_session(0, GOLD, -1, 0);
    for (int m = 0; m < tr_len; m++) begin
      n_tpg += int'(tr_fl[m][5]);
      n_ora += int'(tr_fl[m][3]);
      vectors++;
      if (tr_fl[m] !== model_fl(m, 8, 1, 1'b1, -1, 0)) begin
        miscompares++;
        $display("FAIL pass_flags cyc %0d got %b want %b", m, tr_fl[m], model_fl(m, 8, 1, 1'b1, -1, 0));
      end
      vectors++;
      if (tr_pc[m] != model_pc(m, 8, 1, -1, 0)) begin
        miscompares++;
        $display("FAIL pass_pat cyc %0d got %0d want %0d", m, tr_pc[m], model_pc(m, 8, 1, -1, 0));
      end
    end
    vectors++;
    if (n_tpg != 8 || n_ora != 9) begin
      miscompares++;
      $display("FAIL pass_enable_cycles got tpg=%0d ora=%0d want tpg=8 ora=9", n_tpg, n_ora);
    end
  endtask

  task automatic test_fail();
    run_session(0, 7'h2B, -1, 2);
    for (int m = 0; m < tr_len; m++) begin
      vectors++;
      if (tr_fl[m] !== model_fl(m, 8, 1, 1'b0, -1, 2) || tr_pc[m] != model_pc(m, 8, 1, -1, 2)) begin
        miscompares++;
        $display("FAIL fail_session cyc %0d got %b/%0d want %b/%0d", m, tr_fl[m], tr_pc[m],
                 model_fl(m, 8, 1, 1'b0, -1, 2), model_pc(m, 8, 1, -1, 2));
      end
    end
  endtask

  task automatic test_abort();
    run_session(0, GOLD, 4, 0);
    for (int m = 0; m < tr_len; m++) begin
      vectors++;
      if (tr_fl[m] !== model_fl(m, 8, 1, 1'b1, 4, 0) || tr_pc[m] != model_pc(m, 8, 1, 4, 0)) begin
        miscompares++;
        $display("FAIL abort_session cyc %0d got %b/%0d want %b/%0d", m, tr_fl[m], tr_pc[m],
                 model_fl(m, 8, 1, 1'b1, 4, 0), model_pc(m, 8, 1, 4, 0));
      end
    end
    abort  = 1'b1;
    start0 = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      vectors++;
      if (fl0 !== 8'h00 || pc0 !== 16'd0) begin
        miscompares++;
        $display("FAIL abort_start_idle cyc %0d got %b/%0d want 0/0", k, fl0, pc0);
      end
    end
    abort  = 1'b0;
    start0 = 1'b0;
    tick();
  endtask

  task automatic test_hold_start();
    for (int s = 0; s < 2; s++) begin
      run_session(0, GOLD, -1, 5);
      for (int m = 0; m < tr_len; m++) begin
        vectors++;
        if (tr_fl[m] !== model_fl(m, 8, 1, 1'b1, -1, 5) || tr_pc[m] != model_pc(m, 8, 1, -1, 5)) begin
          miscompares++;
          $display("FAIL hold_start run %0d cyc %0d got %b/%0d want %b/%0d", s, m, tr_fl[m], tr_pc[m],
                   model_fl(m, 8, 1, 1'b1, -1, 5), model_pc(m, 8, 1, -1, 5));
        end
      end
    end
  endtask

  task automatic test_edge();
    int n_tpg = 0;
    int n_ora = 0;
    run_session(1, GOLD, -1, 0);
    for (int m = 0; m < tr_len; m++) begin
      n_tpg += int'(tr_fl[m][5]);
      n_ora += int'(tr_fl[m][3]);
      vectors++;
      if (tr_fl[m] !== model_fl(m, 1, 3, 1'b1, -1, 0) || tr_pc[m] != model_pc(m, 1, 3, -1, 0)) begin
        miscompares++;
        $display("FAIL edge_session cyc %0d got %b/%0d want %b/%0d", m, tr_fl[m], tr_pc[m],
                 model_fl(m, 1, 3, 1'b1, -1, 0), model_pc(m, 1, 3, -1, 0));
      end
    end
    vectors++;
    if (n_tpg != 1 || n_ora != 4 || tr_fl[6][1] !== 1'b1 || tr_fl[5][1] !== 1'b0) begin
      miscompares++;
      $display("FAIL edge_timing got tpg=%0d ora=%0d done@6=%b done@5=%b want 1 4 1 0",
               n_tpg, n_ora, tr_fl[6][1], tr_fl[5][1]);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 10; r++) begin
      int         inst = int'($urandom_range(0, 1));
      int         n    = n_of(inst);
      int         f    = f_of(inst);
      int         hold = int'($urandom_range(0, 3));
      logic [6:0] sig  = ($urandom_range(0, 1) == 0) ? GOLD : 7'($urandom);
      int         ab   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n + f + 2 + hold)) : -1;
      logic       ep   = (sig == GOLD);
      run_session(inst, sig, ab, hold);
      for (int m = 0; m < tr_len; m++) begin
        vectors++;
        if (tr_fl[m] !== model_fl(m, n, f, ep, ab, hold) || tr_pc[m] != model_pc(m, n, f, ab, hold)) begin
          miscompares++;
          $display("FAIL random r%0d inst %0d sig %h ab %0d cyc %0d got %b/%0d want %b/%0d",
                   r, inst, sig, ab, m, tr_fl[m], tr_pc[m],
                   model_fl(m, n, f, ep, ab, hold), model_pc(m, n, f, ab, hold));
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    abort  = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    sig_in = 7'h00;
    test_reset();
    test_pass();
    test_fail();
    test_abort();
    test_hold_start();
    test_edge();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
